// File: rtl/sparse_pe_if.sv
// Output stream of the sparse PE array: product lanes with coordinates, valid/ready handshake.
// The master drives beats; the slave (accumulator scatter stage) returns out_ready.
interface sparse_pe_if #(
    parameter int WORD_LEN  = 8,
    parameter int COORD_LEN = 8,
    parameter int CNT_LEN   = 16,
    parameter int LANES     = 8
);
    logic                          out_valid;
    logic                          out_ready;
    logic [LANES-1:0]              lane_valid;
    logic [LANES*2*WORD_LEN-1:0]   data_out;
    logic [LANES*COORD_LEN-1:0]    data_out_rows;
    logic [LANES*COORD_LEN-1:0]    data_out_cols;
    logic [CNT_LEN-1:0]            out_channel;

    modport master (
        output out_valid, lane_valid, data_out, data_out_rows, data_out_cols, out_channel,
        input  out_ready
    );

    modport slave (
        input  out_valid, lane_valid, data_out, data_out_rows, data_out_cols, out_channel,
        output out_ready
    );
endinterface

// File: rtl/sparse_pe_array.sv
// Sparse-conv PE: Cartesian product of non-zero features x non-zero weights of one channel,
// F_LANES x W_LANES products per beat, output coordinates = feature - weight, halo hits dropped.
module sparse_pe_array #(
    parameter int WORD_LEN  = 8,
    parameter int COORD_LEN = 8,
    parameter int CNT_LEN   = 16,
    parameter int F_LANES   = 4,
    parameter int W_LANES   = 2,
    parameter int MAX_FEAT  = 784,
    parameter int MAX_WGT   = 28,
    parameter int OUT_DIM   = 24
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [CNT_LEN-1:0]            in_channel,
    input  logic [CNT_LEN-1:0]            feature_valid_num,
    input  logic [MAX_FEAT*WORD_LEN-1:0]  feature_value,
    input  logic [MAX_FEAT*COORD_LEN-1:0] feature_rows,
    input  logic [MAX_FEAT*COORD_LEN-1:0] feature_cols,
    input  logic [CNT_LEN-1:0]            weight_valid_num,
    input  logic [MAX_WGT*WORD_LEN-1:0]   weight_value,
    input  logic [MAX_WGT*COORD_LEN-1:0]  weight_rows,
    input  logic [MAX_WGT*COORD_LEN-1:0]  weight_cols,
    output logic                          busy,
    output logic                          done,
    sparse_pe_if.master                   out_if
);
    localparam int LANES = F_LANES * W_LANES;
    localparam int FA_W  = $clog2(MAX_FEAT);
    localparam int WA_W  = $clog2(MAX_WGT);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_EMPTY} state_t;

    state_t state_reg, state_next;

    logic [CNT_LEN-1:0]          f_idx_reg, w_idx_reg;
    logic                        issue_done_reg;
    logic                        out_valid_reg;
    logic [LANES-1:0]            lane_valid_reg;
    logic [LANES*2*WORD_LEN-1:0] data_reg;
    logic [LANES*COORD_LEN-1:0]  rows_reg, cols_reg;
    logic [CNT_LEN-1:0]          channel_reg;

    logic [CNT_LEN-1:0]          nf, nw;
    logic                        f_wrap, last_beat;
    logic                        load_beat, finish;
    logic [LANES-1:0]            lane_ok;
    logic [LANES*2*WORD_LEN-1:0] data_c;
    logic [LANES*COORD_LEN-1:0]  rows_c, cols_c;

    logic signed [WORD_LEN-1:0]  feat_val [MAX_FEAT];
    logic [COORD_LEN-1:0]        feat_row [MAX_FEAT];
    logic [COORD_LEN-1:0]        feat_col [MAX_FEAT];
    logic signed [WORD_LEN-1:0]  wgt_val  [MAX_WGT];
    logic [COORD_LEN-1:0]        wgt_row  [MAX_WGT];
    logic [COORD_LEN-1:0]        wgt_col  [MAX_WGT];

    genvar gi;

    generate
        for (gi = 0; gi < MAX_FEAT; gi++) begin : g_feat
            assign feat_val[gi] = feature_value[gi*WORD_LEN +: WORD_LEN];
            assign feat_row[gi] = feature_rows[gi*COORD_LEN +: COORD_LEN];
            assign feat_col[gi] = feature_cols[gi*COORD_LEN +: COORD_LEN];
        end
        for (gi = 0; gi < MAX_WGT; gi++) begin : g_wgt
            assign wgt_val[gi] = weight_value[gi*WORD_LEN +: WORD_LEN];
            assign wgt_row[gi] = weight_rows[gi*COORD_LEN +: COORD_LEN];
            assign wgt_col[gi] = weight_cols[gi*COORD_LEN +: COORD_LEN];
        end
    endgenerate

    assign nf = (feature_valid_num > CNT_LEN'(MAX_FEAT)) ? CNT_LEN'(MAX_FEAT) : feature_valid_num;
    assign nw = (weight_valid_num > CNT_LEN'(MAX_WGT)) ? CNT_LEN'(MAX_WGT) : weight_valid_num;

    assign f_wrap    = ({1'b0, f_idx_reg} + (CNT_LEN+1)'(F_LANES)) >= {1'b0, nf};
    assign last_beat = f_wrap && (({1'b0, w_idx_reg} + (CNT_LEN+1)'(W_LANES)) >= {1'b0, nw});

    // Lane k = w*F_LANES + f; out-of-list entries read index 0 so array reads stay in range.
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            localparam int FL = gi % F_LANES;
            localparam int WL = gi / F_LANES;
            logic [CNT_LEN:0]             f_ent, w_ent;
            logic                         f_ok, w_ok, in_box;
            logic [FA_W-1:0]              f_sel;
            logic [WA_W-1:0]              w_sel;
            logic [COORD_LEN:0]           r_diff, c_diff;
            logic signed [2*WORD_LEN-1:0] prod;

            assign f_ent  = {1'b0, f_idx_reg} + (CNT_LEN+1)'(FL);
            assign w_ent  = {1'b0, w_idx_reg} + (CNT_LEN+1)'(WL);
            assign f_ok   = f_ent < {1'b0, nf};
            assign w_ok   = w_ent < {1'b0, nw};
            assign f_sel  = f_ok ? f_ent[FA_W-1:0] : '0;
            assign w_sel  = w_ok ? w_ent[WA_W-1:0] : '0;
            assign r_diff = {1'b0, feat_row[f_sel]} - {1'b0, wgt_row[w_sel]};
            assign c_diff = {1'b0, feat_col[f_sel]} - {1'b0, wgt_col[w_sel]};
            // Sign bit of the widened difference flags a negative coordinate.
            assign in_box = !r_diff[COORD_LEN] && !c_diff[COORD_LEN]
                         && (r_diff[COORD_LEN-1:0] < COORD_LEN'(OUT_DIM))
                         && (c_diff[COORD_LEN-1:0] < COORD_LEN'(OUT_DIM));
            assign prod   = feat_val[f_sel] * wgt_val[w_sel];

            assign lane_ok[gi] = f_ok && w_ok && in_box;
            assign data_c[gi*2*WORD_LEN +: 2*WORD_LEN] = lane_ok[gi] ? prod : '0;
            assign rows_c[gi*COORD_LEN +: COORD_LEN]   = lane_ok[gi] ? r_diff[COORD_LEN-1:0] : '0;
            assign cols_c[gi*COORD_LEN +: COORD_LEN]   = lane_ok[gi] ? c_diff[COORD_LEN-1:0] : '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        load_beat  = 1'b0;
        finish     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    if (nf == '0 || nw == '0) begin
                        state_next = ST_EMPTY;
                    end else begin
                        state_next = ST_RUN;
                        load_beat  = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (!out_valid_reg || out_if.out_ready) begin
                    if (!issue_done_reg) begin
                        load_beat = 1'b1;
                    end else if (out_valid_reg) begin
                        finish     = 1'b1;
                        done       = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_EMPTY: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Indices always point at the next beat to load; they rest at 0 while idle so the
    // first beat can be loaded on the start edge itself.
    always_ff @(posedge clk) begin
        if (!rst) begin
            f_idx_reg      <= '0;
            w_idx_reg      <= '0;
            issue_done_reg <= 1'b0;
            out_valid_reg  <= 1'b0;
            lane_valid_reg <= '0;
            data_reg       <= '0;
            rows_reg       <= '0;
            cols_reg       <= '0;
            channel_reg    <= '0;
        end else begin
            if (state_reg == ST_IDLE && start) begin
                channel_reg <= in_channel;
            end
            if (load_beat) begin
                out_valid_reg  <= 1'b1;
                lane_valid_reg <= lane_ok;
                data_reg       <= data_c;
                rows_reg       <= rows_c;
                cols_reg       <= cols_c;
                if (last_beat) begin
                    issue_done_reg <= 1'b1;
                end else if (f_wrap) begin
                    f_idx_reg <= '0;
                    w_idx_reg <= w_idx_reg + CNT_LEN'(W_LANES);
                end else begin
                    f_idx_reg <= f_idx_reg + CNT_LEN'(F_LANES);
                end
            end else if (finish) begin
                out_valid_reg  <= 1'b0;
                lane_valid_reg <= '0;
                data_reg       <= '0;
                rows_reg       <= '0;
                cols_reg       <= '0;
                f_idx_reg      <= '0;
                w_idx_reg      <= '0;
                issue_done_reg <= 1'b0;
            end
        end
    end

    assign out_if.out_valid     = out_valid_reg;
    assign out_if.lane_valid    = lane_valid_reg;
    assign out_if.data_out      = data_reg;
    assign out_if.data_out_rows = rows_reg;
    assign out_if.data_out_cols = cols_reg;
    assign out_if.out_channel   = channel_reg;
endmodule

// File: tb/tb_sparse_pe_array.sv
// Directed bench for sparse_pe_array: reset abort, small product beats, stall, halo drop,
// empty channel and a full-capacity run, checked with immediate assertions.
module tb_sparse_pe_array;
    localparam int WL = 8, CL = 8, NL = 16, FLN = 4, WLN = 2, MF = 784, MW = 28, OD = 24;
    localparam int LN = FLN * WLN;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic [NL-1:0]    in_channel = '0;
    logic [NL-1:0]    feature_valid_num = '0;
    logic [MF*WL-1:0] feature_value = '0;
    logic [MF*CL-1:0] feature_rows = '0;
    logic [MF*CL-1:0] feature_cols = '0;
    logic [NL-1:0]    weight_valid_num = '0;
    logic [MW*WL-1:0] weight_value = '0;
    logic [MW*CL-1:0] weight_rows = '0;
    logic [MW*CL-1:0] weight_cols = '0;
    logic busy, done;

    int total = 0;
    int bad = 0;
    int beat_cnt = 0;
    int done_cnt = 0;

    sparse_pe_if #(.WORD_LEN(WL), .COORD_LEN(CL), .CNT_LEN(NL), .LANES(LN)) pe_if ();

    sparse_pe_array #(
        .WORD_LEN(WL), .COORD_LEN(CL), .CNT_LEN(NL), .F_LANES(FLN), .W_LANES(WLN),
        .MAX_FEAT(MF), .MAX_WGT(MW), .OUT_DIM(OD)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .in_channel(in_channel),
        .feature_valid_num(feature_valid_num), .feature_value(feature_value),
        .feature_rows(feature_rows), .feature_cols(feature_cols),
        .weight_valid_num(weight_valid_num), .weight_value(weight_value),
        .weight_rows(weight_rows), .weight_cols(weight_cols),
        .busy(busy), .done(done), .out_if(pe_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst && pe_if.out_valid && pe_if.out_ready) beat_cnt <= beat_cnt + 1;
        if (rst && done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_feat(input int i, input logic [7:0] v, input logic [7:0] r, input logic [7:0] c);
        feature_value[i*WL +: WL] = v;
        feature_rows[i*CL +: CL]  = r;
        feature_cols[i*CL +: CL]  = c;
    endtask

    task automatic set_wgt(input int i, input logic [7:0] v, input logic [7:0] r, input logic [7:0] c);
        weight_value[i*WL +: WL] = v;
        weight_rows[i*CL +: CL]  = r;
        weight_cols[i*CL +: CL]  = c;
    endtask

    task automatic clear_lists();
        feature_value = '0; feature_rows = '0; feature_cols = '0;
        weight_value  = '0; weight_rows  = '0; weight_cols  = '0;
    endtask

    // Five features at (4,4) and one weight -4 at (1,1): every product lands on (3,3).
    task automatic load_basic();
        clear_lists();
        set_feat(0, 8'sd3, 8'd4, 8'd4);
        set_feat(1, -8'sd2, 8'd4, 8'd4);
        set_feat(2, 8'sd7, 8'd4, 8'd4);
        set_feat(3, 8'sd1, 8'd4, 8'd4);
        set_feat(4, 8'sd5, 8'd4, 8'd4);
        set_wgt(0, -8'sd4, 8'd1, 8'd1);
        feature_valid_num = 16'd5;
        weight_valid_num  = 16'd1;
    endtask

    localparam logic [127:0] B0_DATA = 128'h0000_0000_0000_0000_FFFC_FFE4_0008_FFF4;
    localparam logic [127:0] B0_RC   = 128'h0303_0303;
    localparam logic [127:0] B1_DATA = 128'hFFEC;
    localparam logic [127:0] B1_RC   = 128'h03;

    initial begin
        int b0, d0;
        bit seen;

        pe_if.out_ready = 1'b1;

        // Reset state
        tick(); tick();
        chk("rst_busy",    128'(busy), 128'd0);
        chk("rst_valid",   128'(pe_if.out_valid), 128'd0);
        chk("rst_done",    128'(done), 128'd0);
        chk("rst_lanes",   128'(pe_if.lane_valid), 128'd0);
        chk("rst_data",    pe_if.data_out, 128'd0);
        chk("rst_channel", 128'(pe_if.out_channel), 128'd0);
        rst = 1'b1;
        tick();

        // Test 1: reset held low two cycles in the middle of a stalled run
        load_basic();
        pe_if.out_ready = 1'b0;
        start = 1'b1; in_channel = 16'h0011;
        tick();
        start = 1'b0;
        chk("t1_running", 128'(pe_if.out_valid), 128'd1);
        rst = 1'b0;
        tick();
        chk("t1_busy",  128'(busy), 128'd0);
        chk("t1_valid", 128'(pe_if.out_valid), 128'd0);
        chk("t1_done",  128'(done), 128'd0);
        chk("t1_lanes", 128'(pe_if.lane_valid), 128'd0);
        chk("t1_data",  pe_if.data_out, 128'd0);
        tick();
        rst = 1'b1;
        pe_if.out_ready = 1'b1;
        tick();

        // Test 2: two beats back to back
        b0 = beat_cnt; d0 = done_cnt;
        start = 1'b1; in_channel = 16'h0022;
        tick();
        start = 1'b0;
        $display("t2 beat0 lanes=%h data=%h", pe_if.lane_valid, pe_if.data_out);
        chk("t2_b0_valid", 128'(pe_if.out_valid), 128'd1);
        chk("t2_b0_busy",  128'(busy), 128'd1);
        chk("t2_b0_lanes", 128'(pe_if.lane_valid), 128'h0F);
        chk("t2_b0_data",  pe_if.data_out, B0_DATA);
        chk("t2_b0_rows",  128'(pe_if.data_out_rows), B0_RC);
        chk("t2_b0_cols",  128'(pe_if.data_out_cols), B0_RC);
        chk("t2_b0_done",  128'(done), 128'd0);
        chk("t2_channel",  128'(pe_if.out_channel), 128'h0022);
        tick();
        $display("t2 beat1 lanes=%h data=%h", pe_if.lane_valid, pe_if.data_out);
        chk("t2_b1_lanes", 128'(pe_if.lane_valid), 128'h01);
        chk("t2_b1_data",  pe_if.data_out, B1_DATA);
        chk("t2_b1_rows",  128'(pe_if.data_out_rows), B1_RC);
        chk("t2_b1_done",  128'(done), 128'd1);
        tick();
        chk("t2_end_busy",  128'(busy), 128'd0);
        chk("t2_end_valid", 128'(pe_if.out_valid), 128'd0);
        chk("t2_end_done",  128'(done), 128'd0);
        chk("t2_beats",     128'(beat_cnt - b0), 128'd2);
        chk("t2_dones",     128'(done_cnt - d0), 128'd1);

        // Test 3: backpressure on beat0 for three cycles
        b0 = beat_cnt; d0 = done_cnt;
        pe_if.out_ready = 1'b0;
        start = 1'b1; in_channel = 16'h0033;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            $display("t3 stall cycle %0d lanes=%h data=%h", i, pe_if.lane_valid, pe_if.data_out);
            chk("t3_hold_lanes", 128'(pe_if.lane_valid), 128'h0F);
            chk("t3_hold_data",  pe_if.data_out, B0_DATA);
            chk("t3_hold_rows",  128'(pe_if.data_out_rows), B0_RC);
            chk("t3_hold_done",  128'(done), 128'd0);
            if (i < 2) tick();
        end
        pe_if.out_ready = 1'b1;
        tick();
        chk("t3_b1_lanes", 128'(pe_if.lane_valid), 128'h01);
        chk("t3_b1_data",  pe_if.data_out, B1_DATA);
        chk("t3_b1_done",  128'(done), 128'd1);
        tick();
        chk("t3_end_busy", 128'(busy), 128'd0);
        chk("t3_beats",    128'(beat_cnt - b0), 128'd2);
        chk("t3_dones",    128'(done_cnt - d0), 128'd1);

        // Test 4: halo drop (negative coords and coords >= OUT_DIM) next to in-range lanes
        clear_lists();
        set_feat(0, 8'sd1, 8'd0, 8'd0);
        set_feat(1, 8'sd1, 8'd26, 8'd0);
        set_feat(2, -8'sd1, 8'd23, 8'd23);
        set_wgt(0, 8'sd1, 8'd1, 8'd1);
        set_wgt(1, 8'sd2, 8'd0, 8'd0);
        feature_valid_num = 16'd3;
        weight_valid_num  = 16'd2;
        start = 1'b1; in_channel = 16'h0044;
        tick();
        start = 1'b0;
        $display("t4 beat lanes=%h data=%h", pe_if.lane_valid, pe_if.data_out);
        chk("t4_lanes", 128'(pe_if.lane_valid), 128'h54);
        chk("t4_data",  pe_if.data_out, 128'h0000_FFFE_0000_0002_0000_FFFF_0000_0000);
        chk("t4_rows",  128'(pe_if.data_out_rows), 128'h0017_0000_0016_0000);
        chk("t4_cols",  128'(pe_if.data_out_cols), 128'h0017_0000_0016_0000);
        chk("t4_done",  128'(done), 128'd1);
        tick();
        chk("t4_end_busy", 128'(busy), 128'd0);

        // Test 5: empty weight list
        load_basic();
        weight_valid_num = 16'd0;
        b0 = beat_cnt; d0 = done_cnt;
        start = 1'b1; in_channel = 16'h0055;
        tick();
        start = 1'b0;
        chk("t5_done",    128'(done), 128'd1);
        chk("t5_busy",    128'(busy), 128'd0);
        chk("t5_valid",   128'(pe_if.out_valid), 128'd0);
        chk("t5_channel", 128'(pe_if.out_channel), 128'h0055);
        tick();
        chk("t5_done2",  128'(done), 128'd0);
        chk("t5_busy2",  128'(busy), 128'd0);
        chk("t5_valid2", 128'(pe_if.out_valid), 128'd0);
        chk("t5_beats",  128'(beat_cnt - b0), 128'd0);
        chk("t5_dones",  128'(done_cnt - d0), 128'd1);

        // Test 6: full capacity, counts above capacity clamp, start mid-run ignored
        clear_lists();
        for (int i = 0; i < MF; i++) set_feat(i, 8'(i), 8'(i % 28), 8'(i / 28));
        for (int j = 0; j < MW; j++) set_wgt(j, 8'(j + 1), 8'd0, 8'd0);
        feature_valid_num = 16'd900;
        weight_valid_num  = 16'd40;
        b0 = beat_cnt; d0 = done_cnt;
        seen = 1'b0;
        start = 1'b1; in_channel = 16'h00AA;
        tick();
        start = 1'b0;
        for (int cyc = 0; cyc < 4000 && !seen; cyc++) begin
            if (done) seen = 1'b1;
            start = (cyc == 100);
            in_channel = (cyc == 100) ? 16'h00BB : 16'h00AA;
            if (!seen) tick();
        end
        start = 1'b0;
        chk("t6_done_seen", 128'(seen), 128'd1);
        chk("t6_last_beats", 128'(beat_cnt - b0), 128'd2743);
        tick();
        $display("t6 run beats=%0d dones=%0d", beat_cnt - b0, done_cnt - d0);
        chk("t6_beats",   128'(beat_cnt - b0), 128'd2744);
        chk("t6_dones",   128'(done_cnt - d0), 128'd1);
        chk("t6_busy",    128'(busy), 128'd0);
        chk("t6_channel", 128'(pe_if.out_channel), 128'h00AA);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
